// File: rtl/pc_pkg.sv
// pc_pkg: shared types and defaults for the IF-stage program counter.
// Optional misalignment flag is enabled with PC_ALIGN_CHECK_EN.
package pc_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam int          PC_INC_DEF    = 4;
  localparam int          BOOT_DEF      = 2;

  typedef enum logic [1:0] {
    PC_BOOT = 2'd0,
    PC_RUN  = 2'd1,
    PC_HOLD = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: holds one redirect that arrived while the PC was stalled.
// A trap may replace anything; a branch never replaces a pending trap.
module pc_redirect_buf
  import pc_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            capture,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic [XLEN-1:0] pend_tgt,
  output logic            pend
);

  logic pend_is_trap;
  logic br_ok;

  assign br_ok = !(pend && pend_is_trap);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_tgt     <= '0;
      pend_is_trap <= 1'b0;
      pend         <= 1'b0;
    end else if (clr) begin
      pend_tgt     <= '0;
      pend_is_trap <= 1'b0;
      pend         <= 1'b0;
    end else if (capture && trap_valid) begin
      pend_tgt     <= trap_vec;
      pend_is_trap <= 1'b1;
      pend         <= 1'b1;
    end else if (capture && br_taken && br_ok) begin
      pend_tgt     <= br_target;
      pend_is_trap <= 1'b0;
      pend         <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: IF-stage PC with boot hold-off, stall and buffered redirects.
// Define PC_ALIGN_CHECK_EN to force-align targets and add the misalign flag.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN        = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(RESET_VEC_DEF),
  parameter int              PC_INC      = PC_INC_DEF,
  parameter int              BOOT_CYCLES = BOOT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_rst,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            redirect_pend
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic            misalign
`endif
);

  localparam int CW = $clog2(BOOT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(BOOT_CYCLES - 1);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            capture;
  logic            pend_clr;
  logic            apply;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] pend_tgt;
  logic            pend;

  pc_redirect_buf #(
    .XLEN(XLEN)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (pend_clr),
    .capture   (capture),
    .trap_valid(trap_valid),
    .trap_vec  (trap_vec),
    .br_taken  (br_taken),
    .br_target (br_target),
    .pend_tgt  (pend_tgt),
    .pend      (pend)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    pend_clr = 1'b0;
    apply    = 1'b0;
    tgt      = '0;
    unique case (state_q)
      PC_BOOT: begin
        if (cnt_q == LAST) state_d = PC_RUN;
        else cnt_d = cnt_q + 1'b1;
      end
      PC_RUN: begin
        if (stall) begin
          if (trap_valid || br_taken) begin
            capture = 1'b1;
            state_d = PC_HOLD;
          end
        end else if (trap_valid) begin
          apply = 1'b1;
          tgt   = trap_vec;
        end else if (br_taken) begin
          apply = 1'b1;
          tgt   = br_target;
        end else begin
          pc_d = pc_q + XLEN'(PC_INC);
        end
      end
      PC_HOLD: begin
        if (stall) begin
          capture = 1'b1;
        end else begin
          apply    = 1'b1;
          tgt      = trap_valid ? trap_vec : pend_tgt;
          pend_clr = 1'b1;
          state_d  = PC_RUN;
        end
      end
      default: state_d = PC_BOOT;
    endcase
    if (apply) begin
`ifdef PC_ALIGN_CHECK_EN
      pc_d = {tgt[XLEN-1:2], 2'b00};
`else
      pc_d = tgt;
`endif
    end
    // soft restart skips the boot hold-off entirely
    if (pc_rst) begin
      state_d  = PC_RUN;
      pc_d     = RESET_VEC;
      cnt_d    = cnt_q;
      pend_clr = 1'b1;
      capture  = 1'b0;
      apply    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= PC_BOOT;
      pc_q    <= RESET_VEC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic mis_q;
  always_ff @(posedge clk) begin
    if (!rst) mis_q <= 1'b0;
    else      mis_q <= apply && (tgt[1:0] != 2'b00);
  end
  assign misalign = mis_q;
`endif

  assign pc            = pc_q;
  assign pc_valid      = (state_q != PC_BOOT);
  assign redirect_pend = pend;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit.
// Covers boot, redirects, stall buffering, priority, wrap and reset.
`timescale 1ns/1ps
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        trap_valid;
  logic [31:0] trap_vec;
  logic [31:0] pc;
  logic        pc_valid;
  logic        redirect_pend;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk          (clk),
    .rst          (rst),
    .pc_rst       (pc_rst),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .trap_valid   (trap_valid),
    .trap_vec     (trap_vec),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .redirect_pend(redirect_pend)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misalign     (misalign)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] epc,
                         input logic ev, input logic ep);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".valid"}, {31'd0, pc_valid}, {31'd0, ev});
    chk({tag, ".pend"}, {31'd0, redirect_pend}, {31'd0, ep});
  endtask

  initial begin
    rst = 1'b0; pc_rst = 1'b0; stall = 1'b0;
    br_taken = 1'b0; br_target = '0;
    trap_valid = 1'b0; trap_vec = '0;
    step(); step();
    chk_all("reset", 32'h0, 1'b0, 1'b0);

    rst = 1'b1;
    step(); chk_all("boot1", 32'h0, 1'b0, 1'b0);
    step(); chk_all("boot2", 32'h0, 1'b1, 1'b0);
    step(); chk_all("run4", 32'h4, 1'b1, 1'b0);
    step(); chk("run8", pc, 32'h8);
    step(); chk("runC", pc, 32'hC);
    step(); chk("run10", pc, 32'h10);

    br_taken = 1'b1; br_target = 32'h100;
    step(); chk("br100", pc, 32'h100);
    br_taken = 1'b0;
    step(); chk("br104", pc, 32'h104);

    br_taken = 1'b1; br_target = 32'h1C;
    step(); chk("br1C", pc, 32'h1C);
    br_taken = 1'b0;
    step(); chk("run20", pc, 32'h20);

    stall = 1'b1;
    step(); chk_all("stall_nored", 32'h20, 1'b1, 1'b0);
    br_taken = 1'b1; br_target = 32'h200;
    step(); chk_all("hold0", 32'h20, 1'b1, 1'b1);
    br_taken = 1'b0;
    step(); chk_all("hold1", 32'h20, 1'b1, 1'b1);
    step(); chk_all("hold2", 32'h20, 1'b1, 1'b1);
    step(); chk_all("hold3", 32'h20, 1'b1, 1'b1);
    stall = 1'b0;
    step(); chk_all("release", 32'h200, 1'b1, 1'b0);
    step(); chk("after_rel", pc, 32'h204);

    stall = 1'b1; trap_valid = 1'b1; trap_vec = 32'h80;
    step(); chk_all("trap_pend", 32'h204, 1'b1, 1'b1);
    trap_valid = 1'b0; br_taken = 1'b1; br_target = 32'h300;
    step(); chk_all("br_no_ovr", 32'h204, 1'b1, 1'b1);
    br_taken = 1'b0; stall = 1'b0;
    step(); chk_all("trap_rel", 32'h80, 1'b1, 1'b0);
    step(); chk("after_trap", pc, 32'h84);

    trap_valid = 1'b1; trap_vec = 32'h80;
    br_taken = 1'b1; br_target = 32'h400;
    step(); chk("prio_trap", pc, 32'h80);
    trap_valid = 1'b0; br_taken = 1'b0;
    pc_rst = 1'b1;
    step(); chk_all("pc_rst", 32'h0, 1'b1, 1'b0);
    pc_rst = 1'b0;
    step(); chk("pc_rst_run", pc, 32'h4);

    br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    step(); chk("pre_wrap", pc, 32'hFFFF_FFFC);
    br_taken = 1'b0;
    step(); chk("wrap", pc, 32'h0);

    stall = 1'b1; br_taken = 1'b1; br_target = 32'h600;
    step(); chk("hold_prc", {31'd0, redirect_pend}, 32'd1);
    br_taken = 1'b0; pc_rst = 1'b1;
    step(); chk_all("pc_rst_hold", 32'h0, 1'b1, 1'b0);
    pc_rst = 1'b0; stall = 1'b0;
    step(); chk("prc_rel", pc, 32'h4);

`ifdef PC_ALIGN_CHECK_EN
    br_taken = 1'b1; br_target = 32'h102;
    step(); chk("align_pc", pc, 32'h100);
    chk("mis1", {31'd0, misalign}, 32'd1);
    br_taken = 1'b0;
    step(); chk("mis0", {31'd0, misalign}, 32'd0);
    chk("align_inc", pc, 32'h104);
`else
    br_taken = 1'b1; br_target = 32'h102;
    step(); chk("raw_pc", pc, 32'h102);
    br_taken = 1'b0;
    step(); chk("raw_inc", pc, 32'h106);
`endif

    stall = 1'b1; br_taken = 1'b1; br_target = 32'h500;
    step(); chk("mid_hold", {31'd0, redirect_pend}, 32'd1);
    br_taken = 1'b0; rst = 1'b0;
    step(); chk_all("rst_hold", 32'h0, 1'b0, 1'b0);
    rst = 1'b1; stall = 1'b0;
    br_taken = 1'b1; br_target = 32'h700;
    step(); chk_all("boot_ign1", 32'h0, 1'b0, 1'b0);
    step(); chk_all("boot_ign2", 32'h0, 1'b1, 1'b0);
    br_taken = 1'b0;
    step(); chk("boot_run", pc, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
